// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode constants: opcodes, format codes, alu_op codes and the decoded-entry payload.
package rv_decode_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned ALU_CODE_W = 5;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [ALU_CODE_W-1:0] ALU_NONE = 5'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 5'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 5'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 5'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 5'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 5'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 5'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 5'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 5'd9;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 5'd10;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 5'd11;
    localparam logic [ALU_CODE_W-1:0] ALU_MUL  = 5'd12;

    // Decoded instruction as stored in the skid buffer (PC is held separately, its width is a parameter).
    typedef struct packed {
        logic [6:0]            type_code;
        fmt_e                  fmt;
        logic [ALU_CODE_W-1:0] alu_op;
        logic [REG_IDX_W-1:0]  rs1;
        logic [REG_IDX_W-1:0]  rs2;
        logic [REG_IDX_W-1:0]  rd;
        logic [XLEN-1:0]       imm;
        logic                  rs1_en;
        logic                  rs2_en;
        logic                  rd_we;
        logic                  illegal;
    } dec_t;

    // Base integer op selected by funct3 when no alternate encoding applies.
    function automatic logic [ALU_CODE_W-1:0] base_alu(input logic [2:0] funct3);
        logic [ALU_CODE_W-1:0] op;
        case (funct3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RISC-V immediate generator: sign-extended I/S/B/J, upper U, zero for R/NONE.
module imm_gen
    import rv_decode_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    // Opcode bits never contribute to an immediate.
    logic unused_opc;
    assign unused_opc = ^instr[6:0];

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: decodes on input and holds results in a 2-entry skid buffer.
// Define RV_M_EXT_EN to decode the M extension (funct7=0000001) instead of flagging it illegal.
module instr_decode_stage #(
    parameter int unsigned ALU_OP_W = 10,
    parameter int unsigned PC_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     out_pc,
    output logic [6:0]          out_type_code,
    output logic [2:0]          out_fmt,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [31:0]         out_imm,
    output logic                out_rs1_en,
    output logic                out_rs2_en,
    output logic                out_rd_we,
    output logic                out_illegal
);
    import rv_decode_pkg::*;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    fmt_e                  fmt_c;
    logic [ALU_CODE_W-1:0] alu_c;
    logic                  rs1_en_c, rs2_en_c, rd_we_c, illegal_c;
    logic [XLEN-1:0]       imm_c;
    dec_t                  dec_c;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt_c),
        .imm   (imm_c)
    );

    // Opcode/funct decode; a bad low-bit pair never matches an opcode and lands in default.
    always_comb begin
        fmt_c     = FMT_NONE;
        alu_c     = ALU_NONE;
        rs1_en_c  = 1'b0;
        rs2_en_c  = 1'b0;
        rd_we_c   = 1'b0;
        illegal_c = 1'b0;
        case (opcode)
            OPC_OP: begin
                fmt_c    = FMT_R;
                rs1_en_c = 1'b1;
                rs2_en_c = 1'b1;
                rd_we_c  = 1'b1;
                case (funct7)
                    F7_BASE: alu_c = base_alu(funct3);
                    F7_ALT: begin
                        if (funct3 == 3'd0)      alu_c = ALU_SUB;
                        else if (funct3 == 3'd5) alu_c = ALU_SRA;
                        else                     illegal_c = 1'b1;
                    end
`ifdef RV_M_EXT_EN
                    F7_MULDIV: alu_c = ALU_MUL + ALU_CODE_W'(funct3);
`endif
                    default: illegal_c = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                fmt_c    = FMT_I;
                rs1_en_c = 1'b1;
                rd_we_c  = 1'b1;
                case (funct3)
                    3'd1: begin
                        if (funct7 == F7_BASE) alu_c = ALU_SLL;
                        else                   illegal_c = 1'b1;
                    end
                    3'd5: begin
                        if (funct7 == F7_BASE)     alu_c = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_c = ALU_SRA;
                        else                       illegal_c = 1'b1;
                    end
                    default: alu_c = base_alu(funct3);
                endcase
            end
            OPC_LOAD, OPC_JALR: begin
                fmt_c    = FMT_I;
                alu_c    = ALU_ADD;
                rs1_en_c = 1'b1;
                rd_we_c  = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                fmt_c    = FMT_I;
                rs1_en_c = 1'b1;
                rd_we_c  = 1'b1;
            end
            OPC_STORE: begin
                fmt_c    = FMT_S;
                alu_c    = ALU_ADD;
                rs1_en_c = 1'b1;
                rs2_en_c = 1'b1;
            end
            OPC_BRANCH: begin
                fmt_c    = FMT_B;
                rs1_en_c = 1'b1;
                rs2_en_c = 1'b1;
            end
            OPC_LUI: begin
                fmt_c   = FMT_U;
                rd_we_c = 1'b1;
            end
            OPC_AUIPC: begin
                fmt_c   = FMT_U;
                alu_c   = ALU_ADD;
                rd_we_c = 1'b1;
            end
            OPC_JAL: begin
                fmt_c   = FMT_J;
                rd_we_c = 1'b1;
            end
            default: illegal_c = 1'b1;
        endcase
    end

    // Illegal instructions keep only their format/tag; writes to x0 are never enabled.
    always_comb begin
        dec_c           = '0;
        dec_c.type_code = opcode;
        dec_c.fmt       = fmt_c;
        dec_c.rs1       = in_instr[19:15];
        dec_c.rs2       = in_instr[24:20];
        dec_c.rd        = in_instr[11:7];
        dec_c.imm       = imm_c;
        dec_c.illegal   = illegal_c;
        dec_c.alu_op    = illegal_c ? ALU_NONE : alu_c;
        dec_c.rs1_en    = rs1_en_c && !illegal_c;
        dec_c.rs2_en    = rs2_en_c && !illegal_c;
        dec_c.rd_we     = rd_we_c && !illegal_c && (in_instr[11:7] != 5'd0);
    end

    state_e          state_q, state_d;
    dec_t            head_q, head_d, tail_q, tail_d;
    logic [PC_W-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            accept, drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            head_pc_q   <= '0;
            tail_pc_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            head_pc_q   <= head_pc_d;
            tail_pc_q   <= tail_pc_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Head slot drives the outputs; tail only fills while head is stalled.
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        head_pc_d = head_pc_q;
        tail_pc_d = tail_pc_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d    = dec_c;
                        head_pc_d = in_pc;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        head_d    = dec_c;
                        head_pc_d = in_pc;
                    end else if (accept) begin
                        tail_d    = dec_c;
                        tail_pc_d = in_pc;
                        state_d   = ST_TWO;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        head_d    = tail_q;
                        head_pc_d = tail_pc_q;
                        state_d   = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = head_pc_q;
    assign out_type_code = head_q.type_code;
    assign out_fmt       = head_q.fmt;
    assign out_alu_op    = ALU_OP_W'(head_q.alu_op);
    assign out_rs1       = head_q.rs1;
    assign out_rs2       = head_q.rs2;
    assign out_rd        = head_q.rd;
    assign out_imm       = head_q.imm;
    assign out_rs1_en    = head_q.rs1_en;
    assign out_rs2_en    = head_q.rs2_en;
    assign out_rd_we     = head_q.rd_we;
    assign out_illegal   = head_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage (RV_M_EXT_EN selects M-extension expectations).
module tb_instr_decode_stage;

    localparam int unsigned ALU_OP_W = 10;
    localparam int unsigned PC_W     = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [PC_W-1:0]     in_pc;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [PC_W-1:0]     out_pc;
    logic [6:0]          out_type_code;
    logic [2:0]          out_fmt;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic [4:0]          out_rs1, out_rs2, out_rd;
    logic [31:0]         out_imm;
    logic                out_rs1_en, out_rs2_en, out_rd_we, out_illegal;

    int checks = 0;
    int errors = 0;

    instr_decode_stage #(.ALU_OP_W(ALU_OP_W), .PC_W(PC_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_type_code (out_type_code),
        .out_fmt       (out_fmt),
        .out_alu_op    (out_alu_op),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_rs1_en    (out_rs1_en),
        .out_rs2_en    (out_rs2_en),
        .out_rd_we     (out_rd_we),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for a single cycle with out_ready already set.
    task automatic issue(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL reset_handshake: got %b expected 00", {out_valid, in_ready}); end
        checks++; if ({out_pc, out_imm} !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {out_pc, out_imm}); end
        checks++; if ({out_alu_op, out_rd_we, out_illegal, out_fmt} !== 15'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", {out_alu_op, out_rd_we, out_illegal, out_fmt}); end
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_early: got %b expected 0", in_ready); end
        tick();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL reset_release: got %b expected 01", {out_valid, in_ready}); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(32'h002081B3, 32'h100);
        checks++; if ({out_valid, out_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL add_valid_pc: got %h expected 1_00000100", {out_valid, out_pc}); end
        checks++; if (out_alu_op !== 10'd1) begin errors++; $display("FAIL add_alu_op: got %0d expected 1", out_alu_op); end
        checks++; if ({out_rs1, out_rs2, out_rd} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL add_regs: got %0d %0d %0d expected 1 2 3", out_rs1, out_rs2, out_rd); end
        checks++; if ({out_fmt, out_type_code, out_imm} !== {3'd0, 7'h33, 32'd0}) begin errors++; $display("FAIL add_fmt_imm: got %0d %h %h expected 0 33 0", out_fmt, out_type_code, out_imm); end
        checks++; if ({out_rd_we, out_rs1_en, out_rs2_en, out_illegal} !== 4'b1110) begin errors++; $display("FAIL add_flags: got %b expected 1110", {out_rd_we, out_rs1_en, out_rs2_en, out_illegal}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_formats();
        out_ready = 1'b1;
        issue(32'hFE000EE3, 32'h104);
        checks++; if ({out_fmt, out_imm} !== {3'd3, 32'hFFFFFFFC}) begin errors++; $display("FAIL beq_fmt_imm: got %0d %h expected 3 fffffffc", out_fmt, out_imm); end
        checks++; if ({out_rd_we, out_rs1_en, out_rs2_en, out_alu_op} !== {3'b011, 10'd0}) begin errors++; $display("FAIL beq_flags: got %b %0d expected 011 0", {out_rd_we, out_rs1_en, out_rs2_en}, out_alu_op); end
        issue(32'h123452B7, 32'h108);
        checks++; if ({out_fmt, out_imm, out_rd, out_rd_we, out_rs1_en, out_alu_op} !== {3'd4, 32'h12345000, 5'd5, 1'b1, 1'b0, 10'd0}) begin errors++; $display("FAIL lui: got fmt %0d imm %h rd %0d we %b rs1en %b alu %0d", out_fmt, out_imm, out_rd, out_rd_we, out_rs1_en, out_alu_op); end
        issue(32'hFF9FF0EF, 32'h10C);
        checks++; if ({out_fmt, out_imm, out_rd_we, out_alu_op} !== {3'd5, 32'hFFFFFFF8, 1'b1, 10'd0}) begin errors++; $display("FAIL jal: got fmt %0d imm %h we %b alu %0d expected 5 fffffff8 1 0", out_fmt, out_imm, out_rd_we, out_alu_op); end
        issue(32'h40315093, 32'h110);
        checks++; if ({out_fmt, out_imm, out_alu_op, out_illegal} !== {3'd1, 32'h403, 10'd9, 1'b0}) begin errors++; $display("FAIL srai: got fmt %0d imm %h alu %0d ill %b expected 1 403 9 0", out_fmt, out_imm, out_alu_op, out_illegal); end
        issue(32'h00000013, 32'h114);
        checks++; if ({out_fmt, out_alu_op, out_rd_we, out_rs1_en} !== {3'd1, 10'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL nop_x0: got fmt %0d alu %0d we %b rs1en %b expected 1 1 0 1", out_fmt, out_alu_op, out_rd_we, out_rs1_en); end
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        issue(32'h0000000B, 32'h120);
        checks++; if ({out_illegal, out_alu_op, out_rd_we} !== {1'b1, 10'd0, 1'b0}) begin errors++; $display("FAIL ill_opcode: got ill %b alu %0d we %b expected 1 0 0", out_illegal, out_alu_op, out_rd_we); end
        checks++; if ({out_fmt, out_type_code, out_pc, out_imm} !== {3'd7, 7'h0B, 32'h120, 32'd0}) begin errors++; $display("FAIL ill_opcode_pass: got fmt %0d type %h pc %h imm %h", out_fmt, out_type_code, out_pc, out_imm); end
        issue(32'h4000C0B3, 32'h124);
        checks++; if ({out_illegal, out_alu_op, out_rd_we, out_rs1_en, out_rs2_en, out_fmt} !== {1'b1, 10'd0, 3'b000, 3'd0}) begin errors++; $display("FAIL ill_funct7: got ill %b alu %0d we/en %b fmt %0d expected 1 0 000 0", out_illegal, out_alu_op, {out_rd_we, out_rs1_en, out_rs2_en}, out_fmt); end
        issue(32'h40311093, 32'h128);
        checks++; if ({out_illegal, out_alu_op} !== {1'b1, 10'd0}) begin errors++; $display("FAIL ill_slli: got ill %b alu %0d expected 1 0", out_illegal, out_alu_op); end
        tick();
    endtask

    task automatic test_m_ext();
        out_ready = 1'b1;
        issue(32'h022081B3, 32'h130);
`ifdef RV_M_EXT_EN
        checks++; if ({out_illegal, out_alu_op, out_rd_we} !== {1'b0, 10'd12, 1'b1}) begin errors++; $display("FAIL mul: got ill %b alu %0d we %b expected 0 12 1", out_illegal, out_alu_op, out_rd_we); end
        issue(32'h0220B1B3, 32'h134);
        checks++; if ({out_illegal, out_alu_op} !== {1'b0, 10'd15}) begin errors++; $display("FAIL mulhu: got ill %b alu %0d expected 0 15", out_illegal, out_alu_op); end
`else
        checks++; if ({out_illegal, out_alu_op, out_rd_we} !== {1'b1, 10'd0, 1'b0}) begin errors++; $display("FAIL mul_disabled: got ill %b alu %0d we %b expected 1 0 0", out_illegal, out_alu_op, out_rd_we); end
        issue(32'h0220B1B3, 32'h134);
        checks++; if ({out_illegal, out_alu_op} !== {1'b1, 10'd0}) begin errors++; $display("FAIL mulhu_disabled: got ill %b alu %0d expected 1 0", out_illegal, out_alu_op); end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300;
        tick();
        checks++; if ({out_valid, in_ready, out_pc} !== {2'b11, 32'h300}) begin errors++; $display("FAIL bp_first: got v %b rdy %b pc %h expected 1 1 300", out_valid, in_ready, out_pc); end
        in_instr = 32'h123452B7; in_pc = 32'h304;
        tick();
        checks++; if ({in_ready, out_pc} !== {1'b0, 32'h300}) begin errors++; $display("FAIL bp_full: got rdy %b pc %h expected 0 300", in_ready, out_pc); end
        in_instr = 32'hFE000EE3; in_pc = 32'h308;
        tick();
        checks++; if ({out_valid, in_ready, out_pc, out_rd, out_alu_op} !== {2'b10, 32'h300, 5'd3, 10'd1}) begin errors++; $display("FAIL bp_stable: got v %b rdy %b pc %h rd %0d alu %0d expected 1 0 300 3 1", out_valid, in_ready, out_pc, out_rd, out_alu_op); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if ({out_valid, in_ready, out_pc, out_imm} !== {2'b11, 32'h304, 32'h12345000}) begin errors++; $display("FAIL bp_second: got v %b rdy %b pc %h imm %h expected 1 1 304 12345000", out_valid, in_ready, out_pc, out_imm); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_only_two: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = 32'h00000013;
            in_pc    = 32'h200 + 32'(4 * i);
            tick();
            checks++; if ({out_valid, in_ready, out_pc} !== {2'b11, 32'h200 + 32'(4 * i)}) begin errors++; $display("FAIL b2b_%0d: got v %b rdy %b pc %h expected 1 1 %h", i, out_valid, in_ready, out_pc, 32'h200 + 32'(4 * i)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h400;
        tick();
        in_pc = 32'h404;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup: got rdy %b expected 0", in_ready); end
        flush = 1'b1; in_pc = 32'h408;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_empty: got %b expected 01", {out_valid, in_ready}); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit_%0d: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h500;
        tick();
        in_pc = 32'h504;
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        checks++; if ({out_valid, in_ready, out_pc, out_imm} !== {2'b00, 64'd0}) begin errors++; $display("FAIL midrst: got v %b rdy %b pc %h imm %h expected 0 0 0 0", out_valid, in_ready, out_pc, out_imm); end
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL midrst_release: got %b expected 01", {out_valid, in_ready}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_emit: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_formats();
        test_illegal();
        test_m_ext();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
